// File: rtl/verificador_porta.sv
// -----------------------------------------------------------------------------
// verificador_porta
//
// Purpose:
//   Exhaustive on-board checker for a combinational gate with N_IN inputs and a
//   single output.  A start request walks every input vector 0..2^N_IN-1 onto
//   'entradas'.  Each vector is held for SETTLE cycles, and then 'y' is sampled
//   for one cycle and compared against TRUTH_TABLE.  When the run ends, the
//   block reports pass/fail, the number of mismatches and the first failing
//   vector.
//
// Parameters:
//   N_IN         number of gate inputs (1..4)
//   TRUTH_TABLE  expected output; bit i is the expected y for entradas == i
//   SETTLE       cycles each vector is held before y is sampled (>= 1)
//
// Ports:
//   clock          in   1        rising-edge clock
//   reset_n        in   1        synchronous active-low reset
//   iniciar        in   1        start request, honoured only in OCIOSO
//   y              in   1        gate output under test
//   entradas       out  N_IN     stimulus to the gate (MSB = first input)
//   ocupado        out  1        high while a run is in progress (ESPERA/AMOSTRA)
//   pronto         out  1        one-cycle pulse when a run finishes (FIM)
//   passou         out  1        last run had zero mismatches; held until next start
//   erros          out  N_IN+1   mismatch count of the last/current run
//   primeiro_erro  out  N_IN     first failing vector, meaningful when erros != 0
//   estado_dbg     out  2        current FSM state (OCIOSO=0, ESPERA=1, AMOSTRA=2, FIM=3)
//
// Handshake:
//   iniciar is a level that is sampled only in OCIOSO; a run then cannot be
//   restarted or cancelled except by reset.  pronto is a single-cycle
//   completion strobe with no back-pressure.  erros, primeiro_erro and passou
//   are stable whenever ocupado is low and pronto is low.
// -----------------------------------------------------------------------------
module verificador_porta #(
    parameter int                    N_IN        = 2,
    parameter logic [2**N_IN-1:0]    TRUTH_TABLE = 4'b1000,
    parameter int                    SETTLE      = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            iniciar,
    input  logic            y,
    output logic [N_IN-1:0] entradas,
    output logic            ocupado,
    output logic            pronto,
    output logic            passou,
    output logic [N_IN:0]   erros,
    output logic [N_IN-1:0] primeiro_erro,
    output logic [1:0]      estado_dbg
);

    // Settle counter just needs to hold the value SETTLE.
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [CW-1:0]   CNT_INI = CW'(SETTLE);
    localparam logic [CW-1:0]   CNT_UM  = CW'(1);
    localparam logic [N_IN-1:0] VET_UM  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_UM  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        AMOSTRA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [N_IN-1:0] vetor_q,  vetor_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [N_IN:0]   erros_q,  erros_d;
    logic [N_IN-1:0] prim_q,   prim_d;
    logic            passou_q, passou_d;
    logic            diverge;

    // y is compared against the table entry for the vector currently applied.
    assign diverge = (y != TRUTH_TABLE[vetor_q]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            vetor_q  <= '0;
            cnt_q    <= '0;
            erros_q  <= '0;
            prim_q   <= '0;
            passou_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            vetor_q  <= vetor_d;
            cnt_q    <= cnt_d;
            erros_q  <= erros_d;
            prim_q   <= prim_d;
            passou_q <= passou_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        vetor_d  = vetor_q;
        cnt_d    = cnt_q;
        erros_d  = erros_q;
        prim_d   = prim_q;
        passou_d = passou_q;

        unique case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    erros_d  = '0;
                    prim_d   = '0;
                    passou_d = 1'b0;
                    vetor_d  = '0;
                    cnt_d    = CNT_INI;
                    estado_d = ESPERA;
                end
            end

            ESPERA: begin
                // The counter is loaded with SETTLE, so leaving on a count of 1
                // gives exactly SETTLE cycles in ESPERA.
                if (cnt_q == CNT_UM) begin
                    estado_d = AMOSTRA;
                end else begin
                    cnt_d = cnt_q - CNT_UM;
                end
            end

            AMOSTRA: begin
                if (diverge) begin
                    // erros cannot exceed 2^N_IN, which fits in N_IN+1 bits.
                    erros_d = erros_q + ERR_UM;
                    if (erros_q == '0) begin
                        prim_d = vetor_q;
                    end
                end
                if (&vetor_q) begin
                    // The verdict includes the sample taken in this cycle, so
                    // passou is already valid while pronto is high.
                    passou_d = (erros_q == '0) && !diverge;
                    estado_d = FIM;
                end else begin
                    vetor_d  = vetor_q + VET_UM;
                    cnt_d    = CNT_INI;
                    estado_d = ESPERA;
                end
            end

            FIM: begin
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ocupado = (estado_q == ESPERA) || (estado_q == AMOSTRA);
    end

    assign entradas      = ocupado ? vetor_q : '0;
    assign pronto        = (estado_q == FIM);
    assign passou        = passou_q;
    assign erros         = erros_q;
    assign primeiro_erro = prim_q;
    assign estado_dbg    = estado_q;

endmodule

// File: tb/tb_verificador_porta.sv
module tb_verificador_porta;

    logic       clock;
    logic       reset_n;
    logic       iniciar;
    logic       y;
    logic [1:0] entradas;
    logic       ocupado;
    logic       pronto;
    logic       passou;
    logic [2:0] erros;
    logic [1:0] primeiro_erro;
    logic [1:0] estado_dbg;

    // Gate behaviour driven onto y:
    // 0 = AND, 1 = stuck at 0, 2 = NAND, 3 = AND with vector 01 inverted.
    int modo;

    int n_assert;
    int n_fail;

    verificador_porta #(
        .N_IN        (2),
        .TRUTH_TABLE (4'b1000),
        .SETTLE      (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .iniciar       (iniciar),
        .y             (y),
        .entradas      (entradas),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .passou        (passou),
        .erros         (erros),
        .primeiro_erro (primeiro_erro),
        .estado_dbg    (estado_dbg)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- gate stand-in ----------------
    always_comb begin
        y = 1'b0;
        case (modo)
            0: y = &entradas;
            1: y = 1'b0;
            2: y = ~(&entradas);
            3: y = (entradas == 2'b01) ? 1'b1 : (&entradas);
            default: y = 1'b0;
        endcase
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run from OCIOSO; called at a falling edge with iniciar low.
    // With SETTLE=2 each vector occupies 3 cycles, pronto follows 12 edges after start.
    task automatic run_check(input int m, input logic [2:0] e_err,
                             input logic [1:0] e_prim, input logic e_pass);
        modo    = m;
        iniciar = 1'b1;
        @(negedge clock);          // start captured at the edge just passed
        iniciar = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("entradas_seq", entradas, k / 3);
            chk("ocupado_run", ocupado, 1'b1);
            chk("pronto_early", pronto, 1'b0);
            @(negedge clock);
        end
        chk("pronto_pulse", pronto, 1'b1);
        chk("ocupado_fim", ocupado, 1'b0);
        chk("entradas_fim", entradas, 2'b00);
        chk("estado_fim", estado_dbg, 2'd3);
        @(negedge clock);
        chk("pronto_one_cycle", pronto, 1'b0);
        chk("estado_ocioso", estado_dbg, 2'd0);
        chk("erros", erros, e_err);
        chk("passou", passou, e_pass);
        if (e_err != 3'd0) begin
            chk("primeiro_erro", primeiro_erro, e_prim);
        end
    endtask

    // Global guard against a hung simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int pulsos[$];
    int n_pronto;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        modo     = 0;
        reset_n  = 1'b0;
        iniciar  = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        chk("rst_estado", estado_dbg, 2'd0);
        chk("rst_entradas", entradas, 2'b00);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_passou", passou, 1'b0);
        chk("rst_erros", erros, 3'd0);
        chk("rst_prim", primeiro_erro, 2'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_ocupado", ocupado, 1'b0);

        // ---- 1: correct AND gate ----
        run_check(0, 3'd0, 2'd0, 1'b1);

        // ---- 2: y stuck at 0 ----
        run_check(1, 3'd1, 2'd3, 1'b0);

        // ---- 3: NAND, every vector wrong ----
        run_check(2, 3'd4, 2'd0, 1'b0);
        // results hold while idle
        repeat (5) @(negedge clock);
        chk("hold_erros", erros, 3'd4);
        chk("hold_prim", primeiro_erro, 2'd0);
        chk("hold_passou", passou, 1'b0);

        // ---- 4: only vector 01 wrong ----
        run_check(3, 3'd1, 2'd1, 1'b0);

        // ---- 5: reset in the middle of a run ----
        modo    = 3;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_entradas", entradas, 2'b01);
        chk("mid_ocupado", ocupado, 1'b1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("mrst_estado", estado_dbg, 2'd0);
        chk("mrst_entradas", entradas, 2'b00);
        chk("mrst_ocupado", ocupado, 1'b0);
        chk("mrst_pronto", pronto, 1'b0);
        chk("mrst_passou", passou, 1'b0);
        chk("mrst_erros", erros, 3'd0);
        chk("mrst_prim", primeiro_erro, 2'd0);
        n_pronto = 0;
        for (int c = 0; c < 16; c++) begin
            if (pronto) n_pronto++;
            @(negedge clock);
        end
        chk("mrst_no_pronto", n_pronto, 0);
        run_check(0, 3'd0, 2'd0, 1'b1);

        // ---- 6: iniciar held high, back-to-back runs every 14 cycles ----
        modo    = 0;
        iniciar = 1'b1;
        for (int c = 0; c < 42; c++) begin
            @(negedge clock);
            if (pronto) pulsos.push_back(c);
        end
        iniciar = 1'b0;
        chk("b2b_count", pulsos.size(), 3);
        if (pulsos.size() == 3) begin
            chk("b2b_first", pulsos[0], 12);
            chk("b2b_second", pulsos[1], 26);
            chk("b2b_third", pulsos[2], 40);
        end
        repeat (3) @(negedge clock);
        chk("b2b_estado", estado_dbg, 2'd0);
        chk("b2b_erros", erros, 3'd0);
        chk("b2b_passou", passou, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
